gpio_input_debouncer: RTL and testbench

GPIO_INPUT_DEBOUNCER -- requirements
Module: gpio_input_debouncer

---
 rtl/gpio_input_debouncer.sv | 191 +++++++++++++++++++
 tb/tb_gpio_input_debouncer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_debouncer.sv
// rtl/gpio_input_debouncer.sv - bus-mapped 12-bit GPIO input debouncer with edge flags and interrupt
module gpio_input_debouncer #(
    parameter logic [15:0] DEFAULT_PERIOD = 16'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,
    input  logic [11:0] pad_in,
    output logic [11:0] gpio_in,
    output logic        irq
);
    localparam logic [19:0] BASE_PAGE  = 20'h00021;
    localparam logic [9:0]  IDX_PERIOD = 10'd0;
    localparam logic [9:0]  IDX_RISE   = 10'd1;
    localparam logic [9:0]  IDX_FALL   = 10'd2;
    localparam logic [9:0]  IDX_IRQ_EN = 10'd3;
    localparam logic [9:0]  IDX_RAW    = 10'd4;

    logic              r_gnt;
    logic              r_rvalid;
    logic [31:0]       r_rdata;
    logic [11:0]       r_sync1;
    logic [11:0]       r_sync2;
    logic [11:0]       r_stable;
    logic [11:0][1:0]  r_cnt;
    logic [15:0]       r_presc;
    logic [15:0]       r_period;
    logic [11:0]       r_rise;
    logic [11:0]       r_fall;
    logic [11:0]       r_irq_en;
    logic              r_irq;

    logic              w_decode;
    logic              w_wr;
    logic              w_rd;
    logic [9:0]        w_idx;
    logic [15:0]       w_lane_mask;
    logic [11:0]       w_w1c_bits;
    logic [11:0]       w_rise_clr;
    logic [11:0]       w_fall_clr;
    logic              w_period_wr;
    logic              w_irq_en_wr;
    logic [15:0]       w_presc_max;
    logic              w_tick;
    logic [11:0]       w_stable_nxt;
    logic [11:0][1:0]  w_cnt_nxt;
    logic [11:0]       w_rise_set;
    logic [11:0]       w_fall_set;
    logic [31:0]       w_rdata_nxt;
    logic              w_unused;

    assign w_decode    = (data_addr[31:12] == BASE_PAGE);
    assign w_wr        = data_req && w_decode && data_we;
    assign w_rd        = data_req && w_decode && !data_we;
    assign w_idx       = data_addr[11:2];
    assign w_lane_mask = {{8{data_be[1]}}, {8{data_be[0]}}};
    assign w_w1c_bits  = data_wdata[11:0] & w_lane_mask[11:0];
    assign w_rise_clr  = (w_wr && (w_idx == IDX_RISE)) ? w_w1c_bits : 12'd0;
    assign w_fall_clr  = (w_wr && (w_idx == IDX_FALL)) ? w_w1c_bits : 12'd0;
    assign w_period_wr = w_wr && (w_idx == IDX_PERIOD);
    assign w_irq_en_wr = w_wr && (w_idx == IDX_IRQ_EN);
    assign w_unused    = &{1'b0, data_addr[1:0], data_be[3:2], data_wdata[31:16]};

    // PERIOD of zero behaves like one, so the prescaler ticks every cycle
    assign w_presc_max = (r_period == 16'd0) ? 16'd0 : (r_period - 16'd1);
    assign w_tick      = (r_presc == w_presc_max);

    assign w_rise_set  = w_stable_nxt & ~r_stable;
    assign w_fall_set  = ~w_stable_nxt & r_stable;

    assign data_gnt    = r_gnt;
    assign data_rvalid = r_rvalid;
    assign data_rdata  = r_rdata;
    assign gpio_in     = r_stable;
    assign irq         = r_irq;

    // Single-pulse grant per request, read-valid trails grant by one cycle, read data captured while the read is presented
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
        end else begin
            r_gnt    <= data_req && w_decode && !r_gnt;
            r_rvalid <= r_gnt;
            if (w_rd) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    // Register read mux; unmapped offsets and unused upper bits read zero
    always_comb begin
        w_rdata_nxt = 32'd0;
        case (w_idx)
            IDX_PERIOD: w_rdata_nxt = {16'd0, r_period};
            IDX_RISE:   w_rdata_nxt = {20'd0, r_rise};
            IDX_FALL:   w_rdata_nxt = {20'd0, r_fall};
            IDX_IRQ_EN: w_rdata_nxt = {20'd0, r_irq_en};
            IDX_RAW:    w_rdata_nxt = {20'd0, r_sync2};
            default:    w_rdata_nxt = 32'd0;
        endcase
    end

    // Two-flop synchronizer for the asynchronous pads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 12'd0;
            r_sync2 <= 12'd0;
        end else begin
            r_sync1 <= pad_in;
            r_sync2 <= r_sync1;
        end
    end

    // Prescaler restarts from zero after any PERIOD write so the new period takes effect cleanly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= 16'd0;
        end else if (w_period_wr || w_tick) begin
            r_presc <= 16'd0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end

    // Per-bit debounce: three consecutive disagreeing ticks flip the stable value
    always_comb begin
        w_stable_nxt = r_stable;
        w_cnt_nxt    = r_cnt;
        if (w_tick) begin
            for (int i = 0; i < 12; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    w_cnt_nxt[i] = 2'd0;
                end else if (r_cnt[i] == 2'd2) begin
                    w_stable_nxt[i] = ~r_stable[i];
                    w_cnt_nxt[i]    = 2'd0;
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 2'd1;
                end
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= 12'd0;
            r_cnt    <= '0;
        end else begin
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Software registers; a hardware edge wins over a same-cycle write-one-to-clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_period <= DEFAULT_PERIOD;
            r_irq_en <= 12'd0;
            r_rise   <= 12'd0;
            r_fall   <= 12'd0;
        end else begin
            if (w_period_wr) begin
                r_period <= (r_period & ~w_lane_mask) | (data_wdata[15:0] & w_lane_mask);
            end
            if (w_irq_en_wr) begin
                r_irq_en <= (r_irq_en & ~w_lane_mask[11:0]) | (data_wdata[11:0] & w_lane_mask[11:0]);
            end
            r_rise <= (r_rise & ~w_rise_clr) | w_rise_set;
            r_fall <= (r_fall & ~w_fall_clr) | w_fall_set;
        end
    end

    // Level interrupt, registered one cycle behind the flag/enable state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |((r_rise | r_fall) & r_irq_en);
        end
    end

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// tb/tb_gpio_input_debouncer.sv - randomized self-checking bench against a behavioural model
module tb_gpio_input_debouncer;
    localparam logic [31:0] BASE = 32'h0002_1000;

    logic        clk;
    logic        rst;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic [11:0] pad_in;
    logic [11:0] gpio_in;
    logic        irq;

    gpio_input_debouncer #(.DEFAULT_PERIOD(16'd1000)) dut (
        .clk(clk), .rst(rst),
        .data_req(data_req), .data_we(data_we), .data_be(data_be),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .pad_in(pad_in), .gpio_in(gpio_in), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state
    logic [15:0] m_period;
    int          m_since;
    logic [11:0] m_s1, m_s2, m_stable, m_rise, m_fall, m_en;
    logic        m_irq;
    logic [11:0] m_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_period = 16'd1000;
        m_since  = 0;
        m_s1 = '0; m_s2 = '0; m_stable = '0;
        m_rise = '0; m_fall = '0; m_en = '0;
        m_irq = 1'b0;
        m_hist.delete();
    endtask

    function automatic logic [31:0] model_rd(input logic [11:0] off);
        case (off[11:2])
            10'd0:   return {16'd0, m_period};
            10'd1:   return {20'd0, m_rise};
            10'd2:   return {20'd0, m_fall};
            10'd3:   return {20'd0, m_en};
            10'd4:   return {20'd0, m_s2};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the model: a bit flips once the last three tick samples all disagree with it
    task automatic model_edge(input logic rq, input logic we, input logic [3:0] be,
                              input logic [31:0] a, input logic [31:0] wd, input logic [11:0] pad);
        int          eff;
        bit          tick;
        bit          wr;
        logic [11:0] nst, clr_r, clr_f, w1c;
        logic [15:0] mask;
        eff  = (m_period == 16'd0) ? 1 : int'(m_period);
        tick = ((m_since % eff) == eff - 1);
        nst  = m_stable;
        if (tick) begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > 3) void'(m_hist.pop_front());
            if (m_hist.size() == 3) begin
                for (int i = 0; i < 12; i++) begin
                    if (m_hist[0][i] != m_stable[i] && m_hist[1][i] != m_stable[i] && m_hist[2][i] != m_stable[i])
                        nst[i] = ~m_stable[i];
                end
            end
        end
        wr    = rq && we && (a[31:12] == 20'h00021);
        mask  = {{8{be[1]}}, {8{be[0]}}};
        w1c   = wd[11:0] & mask[11:0];
        clr_r = (wr && a[11:2] == 10'd1) ? w1c : 12'd0;
        clr_f = (wr && a[11:2] == 10'd2) ? w1c : 12'd0;
        m_irq = |((m_rise | m_fall) & m_en);
        m_rise = (m_rise & ~clr_r) | (nst & ~m_stable);
        m_fall = (m_fall & ~clr_f) | (~nst & m_stable);
        if (wr && a[11:2] == 10'd3) m_en = (m_en & ~mask[11:0]) | (wd[11:0] & mask[11:0]);
        if (wr && a[11:2] == 10'd0) begin
            m_period = (m_period & ~mask) | (wd[15:0] & mask);
            m_since  = 0;
        end else begin
            m_since++;
        end
        m_stable = nst;
        m_s2 = m_s1;
        m_s1 = pad;
    endtask

    task automatic cyc();
        logic rq, we;
        logic [3:0] be;
        logic [31:0] a, wd;
        logic [11:0] pd;
        rq = data_req; we = data_we; be = data_be; a = data_addr; wd = data_wdata; pd = pad_in;
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge(rq, we, be, a, wd, pd);
        #1;
        chk("gpio_in", {20'd0, gpio_in}, {20'd0, m_stable});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic bus_read(input logic [11:0] off, input string tag, output logic [31:0] rd);
        logic [31:0] exp;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = BASE | {20'd0, off};
        cyc();
        chk({tag, "_gnt"}, {31'd0, data_gnt}, 32'd1);
        chk({tag, "_rvalid_early"}, {31'd0, data_rvalid}, 32'd0);
        exp = model_rd(off);
        cyc();
        data_req = 1'b0;
        chk({tag, "_gnt_single"}, {31'd0, data_gnt}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, data_rvalid}, 32'd1);
        chk({tag, "_rdata"}, data_rdata, exp);
        rd = data_rdata;
    endtask

    task automatic bus_write(input logic [11:0] off, input logic [3:0] be, input logic [31:0] wd);
        data_req = 1'b1; data_we = 1'b1; data_be = be; data_addr = BASE | {20'd0, off}; data_wdata = wd;
        cyc();
        chk("wr_gnt", {31'd0, data_gnt}, 32'd1);
        cyc();
        chk("wr_rvalid", {31'd0, data_rvalid}, 32'd1);
        data_req = 1'b0; data_we = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [11:0] offs [7];
        offs = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'hFFC};

        rst = 1'b0; data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
        data_addr = BASE; data_wdata = 32'd0; pad_in = 12'd0;
        model_reset();
        #1;
        chk("rst_gnt", {31'd0, data_gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, data_rvalid}, 32'd0);
        chk("rst_rdata", data_rdata, 32'd0);
        run(3);
        rst = 1'b1;
        run(2);

        // Reset values readable; unmapped offset reads zero
        bus_read(12'h000, "period_rst", rd);
        chk("period_rst_const", rd, 32'h0000_03E8);
        bus_read(12'h014, "off14", rd);
        chk("off14_const", rd, 32'd0);

        // Requests outside the window are ignored
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0002_2000;
        cyc();
        chk("nodecode_gnt", {31'd0, data_gnt}, 32'd0);
        data_req = 1'b0;
        cyc();
        chk("nodecode_rvalid", {31'd0, data_rvalid}, 32'd0);

        // PERIOD=4 rising edge on pad 3
        bus_write(12'h000, 4'h3, 32'd4);
        pad_in[3] = 1'b1;
        lat = 0;
        while (gpio_in[3] == 1'b0 && lat < 40) begin
            cyc();
            lat++;
        end
        chk("rise_latency_ok", {31'd0, (lat <= 18)}, 32'd1);
        bus_read(12'h004, "rise3", rd);
        chk("rise3_const", rd, 32'h0000_0008);
        bus_read(12'h008, "fall_none", rd);
        chk("fall_none_const", rd, 32'd0);
        bus_write(12'h004, 4'hF, 32'h8);
        pad_in[3] = 1'b0;
        run(20);
        bus_write(12'h008, 4'hF, 32'hFFF);

        // 8-cycle glitch at PERIOD=4 has no effect
        pad_in[0] = 1'b1;
        run(8);
        pad_in[0] = 1'b0;
        run(20);
        chk("glitch_gpio", {20'd0, gpio_in}, 32'd0);
        bus_read(12'h004, "glitch_rise", rd);
        chk("glitch_rise_const", rd, 32'd0);

        // Interrupt from RISE[0], cleared by W1C
        bus_write(12'h00C, 4'hF, 32'h001);
        pad_in[0] = 1'b1;
        run(20);
        chk("irq_set_const", {31'd0, irq}, 32'd1);
        bus_write(12'h004, 4'hF, 32'h001);
        chk("irq_clr_const", {31'd0, irq}, 32'd0);
        bus_read(12'h004, "rise_clr", rd);

        // PERIOD=0: every cycle ticks; hardware set collides with W1C
        bus_write(12'h000, 4'h3, 32'd0);
        pad_in[0] = 1'b0;
        run(8);
        bus_write(12'h008, 4'hF, 32'hFFF);
        pad_in[0] = 1'b1;
        run(3);
        bus_write(12'h004, 4'hF, 32'h001);
        bus_read(12'h004, "set_prio", rd);
        chk("set_prio_const", {31'd0, rd[0]}, 32'd1);

        pad_in[5] = 1'b1;
        run(4);
        chk("p0_lat_before", {31'd0, gpio_in[5]}, 32'd0);
        cyc();
        chk("p0_lat_at5", {31'd0, gpio_in[5]}, 32'd1);

        // Partial byte-lane write to PERIOD
        bus_write(12'h000, 4'h2, 32'h0000_AB12);
        bus_read(12'h000, "period_lane", rd);
        chk("period_lane_const", rd, 32'h0000_AB00);
        bus_write(12'h000, 4'h3, 32'd2);

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            int op;
            op = $urandom_range(0, 11);
            if ($urandom_range(0, 3) == 0) pad_in[$urandom_range(0, 11)] ^= 1'b1;
            case (op)
                6: bus_write(12'h000, 4'h3, 32'($urandom_range(0, 3)));
                7: bus_write(12'h004, 4'($urandom_range(0, 15)), $urandom);
                8: bus_write(12'h008, 4'($urandom_range(0, 15)), $urandom);
                9: bus_write(12'h00C, 4'($urandom_range(0, 15)), $urandom);
                10: bus_read(offs[$urandom_range(0, 6)], "rand_rd", rd);
                default: cyc();
            endcase
        end

        // Known state, then reset in the middle of a read
        bus_write(12'h000, 4'h3, 32'd0);
        bus_write(12'h00C, 4'hF, 32'hFFF);
        pad_in = 12'hFFF;
        run(10);
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = BASE;
        cyc();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("midrst_gnt", {31'd0, data_gnt}, 32'd0);
        chk("midrst_rvalid", {31'd0, data_rvalid}, 32'd0);
        chk("midrst_rdata", data_rdata, 32'd0);
        chk("midrst_gpio", {20'd0, gpio_in}, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        data_req = 1'b0;
        run(2);
        rst = 1'b1;
        cyc();
        chk("postrst_gnt", {31'd0, data_gnt}, 32'd0);
        cyc();
        chk("postrst_rvalid", {31'd0, data_rvalid}, 32'd0);
        bus_read(12'h000, "period_after_rst", rd);
        chk("period_after_rst_const", rd, 32'h0000_03E8);

        // Pads held high through reset report RISE after release
        run(3010);
        bus_read(12'h004, "rise_thru_rst", rd);
        chk("rise_thru_rst_const", rd, 32'h0000_0FFF);
        bus_write(12'h004, 4'hF, 32'hFFF);
        bus_read(12'h004, "rise_thru_rst_clr", rd);
        chk("rise_thru_rst_clr_const", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
